// File: rtl/microarchtrace_event_buffer.sv
// Pipeline-stage event tracer: classifies busy/done activity into SINGLE/START/END
// records, timestamps them into per-stage FIFOs and drains them round-robin.
module microarchtrace_event_buffer #(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned TS_W       = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DROP_W     = 16,
  localparam int unsigned SW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       trace_en,
  input  logic [NUM_STAGES-1:0]      stage_busy,
  input  logic [NUM_STAGES-1:0]      stage_done,
  input  logic [NUM_STAGES*PC_W-1:0] stage_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SW-1:0]              out_stage,
  output logic [1:0]                 out_type,
  output logic [TS_W-1:0]            out_ts,
  output logic [PC_W-1:0]            out_pc,
  output logic                       out_lost,
  output logic [DROP_W-1:0]          drop_count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned REC_W = 3 + TS_W + PC_W;
  localparam int unsigned SUM_W = DROP_W + 4;

  localparam logic [1:0] EV_SINGLE = 2'd0;
  localparam logic [1:0] EV_START  = 2'd1;
  localparam logic [1:0] EV_END    = 2'd2;

  logic [TS_W-1:0]       ts;
  logic [NUM_STAGES-1:0] busy_q, done_q, multi;
  logic [NUM_STAGES-1:0] ev_valid, push, drop, pop, full, nonempty, lost_q;
  logic [1:0]            ev_type [NUM_STAGES];
  logic [PC_W-1:0]       pc_arr  [NUM_STAGES];
  logic [AW:0]           wr_ptr  [NUM_STAGES];
  logic [AW:0]           rd_ptr  [NUM_STAGES];
  logic [REC_W-1:0]      mem     [NUM_STAGES][DEPTH];

  logic [SW-1:0]         rr_ptr, search_idx, grant, lock_idx_q;
  logic                  locked_q, found, handshake;
  int unsigned           idx;
  logic [REC_W-1:0]      head;
  logic [3:0]            n_drop;
  logic [SUM_W-1:0]      drop_sum;
  logic [DROP_W-1:0]     drop_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts     <= '0;
      busy_q <= '0;
      done_q <= '0;
    end else begin
      ts     <= ts + TS_W'(1);
      busy_q <= stage_busy;
      done_q <= stage_done;
    end
  end

  assign multi = busy_q & ~done_q;

  always_comb begin
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      pc_arr[i]   = stage_pc[i*PC_W +: PC_W];
      ev_valid[i] = 1'b0;
      ev_type[i]  = EV_SINGLE;
      if (trace_en && stage_busy[i]) begin
        if (stage_done[i]) begin
          ev_valid[i] = 1'b1;
          ev_type[i]  = multi[i] ? EV_END : EV_SINGLE;
        end else if (!multi[i]) begin
          ev_valid[i] = 1'b1;
          ev_type[i]  = EV_START;
        end
      end
    end
  end

  // Fullness uses pre-edge occupancy only, so a same-cycle pop never frees a slot.
  always_comb begin
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      full[i]     = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                    (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      nonempty[i] = (wr_ptr[i] != rd_ptr[i]);
      push[i]     = ev_valid[i] & ~full[i];
      drop[i]     = ev_valid[i] & full[i];
    end
  end

  always_comb begin
    search_idx = '0;
    found      = 1'b0;
    idx        = 0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_STAGES) idx = idx - NUM_STAGES;
      if (!found && nonempty[SW'(idx)]) begin
        found      = 1'b1;
        search_idx = SW'(idx);
      end
    end
  end

  // A stalled grant is latched so a newly filled lower-index FIFO cannot steal it.
  assign grant     = locked_q ? lock_idx_q : search_idx;
  assign out_valid = |nonempty;
  assign handshake = out_valid & out_ready;
  assign head      = mem[grant][rd_ptr[grant][AW-1:0]];

  always_comb begin
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      pop[i] = handshake && (grant == SW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      locked_q   <= out_valid & ~out_ready;
      lock_idx_q <= grant;
      if (handshake) begin
        rr_ptr <= (32'(grant) == NUM_STAGES - 1) ? '0 : grant + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_q <= '0;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + (AW+1)'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + (AW+1)'(1);
        if (drop[i])      lost_q[i] <= 1'b1;
        else if (push[i]) lost_q[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i][AW-1:0]] <= {lost_q[i], ev_type[i], ts, pc_arr[i]};
      end
    end
  end

  always_comb begin
    n_drop = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      n_drop = n_drop + 4'(drop[i]);
    end
    drop_sum  = SUM_W'(drop_count) + SUM_W'(n_drop);
    drop_next = (|drop_sum[SUM_W-1:DROP_W]) ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_count <= '0;
    else        drop_count <= drop_next;
  end

  always_comb begin
    out_stage = '0;
    out_type  = '0;
    out_ts    = '0;
    out_pc    = '0;
    out_lost  = 1'b0;
    if (out_valid) begin
      out_stage = grant;
      out_lost  = head[REC_W-1];
      out_type  = head[REC_W-2 -: 2];
      out_ts    = head[PC_W +: TS_W];
      out_pc    = head[PC_W-1:0];
    end
  end

endmodule

// File: tb/tb_microarchtrace_event_buffer.sv
// Directed bench for microarchtrace_event_buffer with per-stage scoreboards
// filled at stimulus time and consumed on each output handshake.
module tb_microarchtrace_event_buffer;

  localparam logic [1:0] T_SINGLE = 2'd0;
  localparam logic [1:0] T_START  = 2'd1;
  localparam logic [1:0] T_END    = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n, trace_en, out_ready;
  logic [1:0]  stage_busy, stage_done;
  logic [31:0] pc0, pc1;
  logic [63:0] stage_pc;
  logic        out_valid, out_lost;
  logic [0:0]  out_stage;
  logic [1:0]  out_type;
  logic [15:0] out_ts, drop_count;
  logic [31:0] out_pc;

  assign stage_pc = {pc1, pc0};
  always #5 clk = ~clk;

  microarchtrace_event_buffer #(
    .NUM_STAGES(2), .PC_W(32), .TS_W(16), .DEPTH(4), .DROP_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trace_en(trace_en),
    .stage_busy(stage_busy), .stage_done(stage_done), .stage_pc(stage_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_stage(out_stage),
    .out_type(out_type), .out_ts(out_ts), .out_pc(out_pc),
    .out_lost(out_lost), .drop_count(drop_count)
  );

  typedef struct packed {
    logic [1:0]  typ;
    logic [15:0] ts;
    logic [31:0] pc;
    logic        lost;
  } rec_t;

  rec_t sb0[$];
  rec_t sb1[$];
  int   ord[$];
  int   n_err = 0, n_checks = 0, ts_model = 0, hs_count = 0, bp_ts = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_rec(input rec_t e, input string pfx);
    chk({pfx, "_type"}, out_type, e.typ);
    chk({pfx, "_ts"},   out_ts,   e.ts);
    chk({pfx, "_pc"},   out_pc,   e.pc);
    chk({pfx, "_lost"}, out_lost, e.lost);
  endtask

  task automatic check_pop();
    rec_t e;
    hs_count++;
    if (ord.size() > 0) chk("rr_order", out_stage, ord.pop_front());
    if (out_stage == 1'b0) begin
      chk("sb0_pending", sb0.size() > 0, 1);
      if (sb0.size() > 0) begin e = sb0.pop_front(); cmp_rec(e, "s0"); end
    end else begin
      chk("sb1_pending", sb1.size() > 0, 1);
      if (sb1.size() > 0) begin e = sb1.pop_front(); cmp_rec(e, "s1"); end
    end
  endtask

  task automatic tick();
    if (out_valid && out_ready) check_pop();
    @(posedge clk);
    ts_model++;
    #1;
  endtask

  task automatic drive(input logic b0, input logic d0, input logic [31:0] p0,
                       input logic b1, input logic d1, input logic [31:0] p1);
    stage_busy = {b1, b0};
    stage_done = {d1, d0};
    pc0 = p0;
    pc1 = p1;
  endtask

  task automatic idle();
    stage_busy = '0;
    stage_done = '0;
  endtask

  task automatic exp_rec(input int stage, input logic [1:0] typ, input logic [31:0] pc,
                         input logic lost);
    rec_t r;
    r.typ  = typ;
    r.ts   = 16'(ts_model);
    r.pc   = pc;
    r.lost = lost;
    if (stage == 0) sb0.push_back(r);
    else            sb1.push_back(r);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40; k++) begin
      if (sb0.size() == 0 && sb1.size() == 0 && !out_valid) break;
      tick();
    end
    chk({tag, "_sb0_empty"}, sb0.size(), 0);
    chk({tag, "_sb1_empty"}, sb1.size(), 0);
    chk({tag, "_idle"}, out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; trace_en = 1'b1; out_ready = 1'b1;
    idle(); pc0 = '0; pc1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_stage", out_stage, 0);
    chk("rst_type",  out_type, 0);
    chk("rst_ts",    out_ts, 0);
    chk("rst_pc",    out_pc, 0);
    chk("rst_lost",  out_lost, 0);
    chk("rst_drop",  drop_count, 0);
    rst_n = 1'b1;
    ts_model = 0;

    // Single-cycle event at ts=5
    while (ts_model < 5) tick();
    drive(1, 1, 32'h80, 0, 0, 0);
    exp_rec(0, T_SINGLE, 32'h80, 0);
    tick();
    idle();
    chk("single_valid", out_valid, 1);
    chk("single_stage", out_stage, 0);
    chk("single_type",  out_type, T_SINGLE);
    chk("single_ts",    out_ts, 5);
    chk("single_pc",    out_pc, 32'h80);
    chk("single_lost",  out_lost, 0);
    drain("single");

    // Multicycle on stage1: START at 10, END at 12
    while (ts_model < 10) tick();
    hs_count = 0;
    drive(0, 0, 0, 1, 0, 32'h100);
    exp_rec(1, T_START, 32'h100, 0);
    tick();
    tick();
    drive(0, 0, 0, 1, 1, 32'h100);
    exp_rec(1, T_END, 32'h100, 0);
    tick();
    idle();
    drain("multi");
    chk("multi_count", hs_count, 2);

    // Simultaneous events, round-robin order
    ord = {0, 1, 0, 1};
    drive(1, 1, 32'hA0, 1, 1, 32'hB0);
    exp_rec(0, T_SINGLE, 32'hA0, 0);
    exp_rec(1, T_SINGLE, 32'hB0, 0);
    tick();
    drive(1, 1, 32'hA1, 1, 1, 32'hB1);
    exp_rec(0, T_SINGLE, 32'hA1, 0);
    exp_rec(1, T_SINGLE, 32'hB1, 0);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      chk("rr_thru_valid", out_valid, 1);
      tick();
    end
    chk("rr_done_idle", out_valid, 0);
    chk("rr_order_used", ord.size(), 0);
    drain("rr");

    // Overflow: 6 events into a 4-deep FIFO with the sink stalled
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 32'h200 + 32'(k), 0, 0, 0);
      if (k < 4) exp_rec(0, T_SINGLE, 32'h200 + 32'(k), 0);
      tick();
    end
    idle();
    chk("ovf_drop", drop_count, 2);
    chk("ovf_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    drive(1, 1, 32'h300, 0, 0, 0);
    exp_rec(0, T_SINGLE, 32'h300, 1);
    tick();
    idle();
    drain("ovf");
    chk("ovf_drop_after", drop_count, 2);

    // Backpressure: stalled stage1 record must hold while stage0 fills
    drive(0, 0, 0, 1, 1, 32'h3F0);
    exp_rec(1, T_SINGLE, 32'h3F0, 0);
    tick();
    idle();
    drain("bp_pre");
    out_ready = 1'b0;
    bp_ts = ts_model;
    drive(0, 0, 0, 1, 1, 32'h400);
    exp_rec(1, T_SINGLE, 32'h400, 0);
    tick();
    idle();
    chk("bp_valid0", out_valid, 1);
    chk("bp_stage0", out_stage, 1);
    chk("bp_pc0",    out_pc, 32'h400);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 32'h500 + 32'(k), 0, 0, 0);
      exp_rec(0, T_SINGLE, 32'h500 + 32'(k), 0);
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_stage", out_stage, 1);
      chk("bp_hold_pc",    out_pc, 32'h400);
      chk("bp_hold_ts",    out_ts, 16'(bp_ts));
      chk("bp_hold_type",  out_type, T_SINGLE);
    end
    idle();
    out_ready = 1'b1;
    ord = {1};
    drain("bp");

    // Reset mid-multicycle with three records buffered
    out_ready = 1'b0;
    drive(1, 1, 32'h600, 1, 0, 32'h700);
    tick();
    drive(1, 1, 32'h601, 1, 0, 32'h700);
    tick();
    drive(0, 0, 0, 1, 0, 32'h700);
    chk("prerst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_drop",  drop_count, 0);
    chk("midrst_pc",    out_pc, 0);
    sb0.delete();
    sb1.delete();
    ord.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ts_model = 0;
    out_ready = 1'b1;
    exp_rec(1, T_START, 32'h700, 0);
    tick();
    drive(0, 0, 0, 1, 1, 32'h700);
    exp_rec(1, T_END, 32'h700, 0);
    tick();
    idle();
    drain("rst");

    // trace_en low mid-multicycle; buffered record drains while disabled
    out_ready = 1'b0;
    drive(1, 0, 32'h800, 0, 0, 0);
    exp_rec(0, T_START, 32'h800, 0);
    tick();
    trace_en = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("en_off_drained", sb0.size(), 0);
    chk("en_off_idle", out_valid, 0);
    trace_en = 1'b1;
    drive(1, 1, 32'h800, 0, 0, 0);
    exp_rec(0, T_END, 32'h800, 0);
    tick();
    idle();
    drain("en");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/microarchtrace_event_buffer.md
Name: microarchtrace_event_buffer

Overview:
- Synthesizable, parametrised successor to the DPI-based pipeline tracer.
- Monitors NUM_STAGES pipeline stages, each with a busy/done pair and a PC.
- Classifies each stage's activity as SINGLE, START or END events, timestamps them and buffers them in per-stage FIFOs.
- Drains the FIFOs round-robin onto one valid/ready stream for an on-chip trace sink; drop accounting covers overflow.

Parameters:
NUM_STAGES, 2, number of monitored stages (1..8)
PC_W, 32, PC width
TS_W, 16, timestamp counter width
DEPTH, 4, per-stage FIFO depth in entries (power of two, >=2)
DROP_W, 16, width of the saturating drop counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
trace_en  in  1  event detection enable
stage_busy  in  NUM_STAGES  stage holds an instruction this cycle
stage_done  in  NUM_STAGES  stage completes this cycle
stage_pc  in  NUM_STAGES*PC_W  per-stage PC; stage i uses bits [i*PC_W +: PC_W]
out_valid  out  1  event record available
out_ready  in  1  sink accepts record
out_stage  out  max(1,$clog2(NUM_STAGES))  source stage index
out_type  out  2  0=SINGLE, 1=START, 2=END (3 is never emitted)
out_ts  out  TS_W  timestamp of the detection cycle
out_pc  out  PC_W  PC captured at detection
out_lost  out  1  one or more earlier events of this stage were dropped
drop_count  out  DROP_W  total dropped events, saturating

Behaviour:
- Reset (async assert, sync release): all history registers, FIFOs, lost flags, the RR pointer, ts and drop_count are cleared. out_valid=0 and all data outputs are 0.
- ts increments every clk edge after reset and wraps from 2^TS_W-1 to 0. It keeps counting regardless of trace_en.
- Per-stage history: busy_q/done_q register stage_busy/stage_done every cycle, also when trace_en=0. multi = busy_q & ~done_q.
- Event classification for stage i, evaluated only when trace_en=1:
  - busy & done & multi -> END
  - busy & done & ~multi -> SINGLE
  - busy & ~done & ~multi -> START
  - anything else -> no event
- Push: the record {type, current ts, pc} is written to FIFO i on the same edge. out_valid can rise at the earliest one cycle after the detection edge.
- Full check is made on the pre-edge occupancy. A pop of the same FIFO in that cycle does not make room.
- Overflow, when an event hits a full FIFO:
  - the event is dropped;
  - lost_i is set;
  - drop_count increments and saturates at 2^DROP_W-1.
- The next successfully pushed event of stage i carries lost=1, and lost_i clears on that same edge. A drop and a push cannot coincide for one stage.
- Output arbiter:
  - RR pointer p; grant goes to the first non-empty FIFO searching from p upward, modulo NUM_STAGES.
  - out_* comes from the granted FIFO head.
  - While out_valid & ~out_ready, the grant and all out_* stay stable.
  - On handshake the head is popped and p = grant+1 mod NUM_STAGES. If there is no handshake, p is unchanged.
- out_valid=0 while all FIFOs are empty. out_* data is don't-care then and is driven as 0.
- Throughput: one record per cycle when out_ready=1 and any FIFO is non-empty.
- Reset mid-multicycle: history is cleared, so a still-busy stage emits START on its first traced cycle after reset. An END with no preceding START is legal.
- trace_en falling mid-multicycle: no events while it is low. On re-enable, detection continues from the true history, so no spurious START is produced.
- Buffered records are still drained while trace_en=0.

Test Plan:
- Single-cycle: NUM_STAGES=2, out_ready=1. Stage0 busy=done=1 for one cycle at ts=5 with pc=0x80 -> next cycle out_valid=1, stage=0, type=SINGLE, ts=5, pc=0x80, lost=0.
- Multicycle: stage1 busy for 3 cycles, done only in the third (pc=0x100, ts 10..12) -> exactly two records: START ts=10 and END ts=12, both pc=0x100.
- Simultaneous/RR: both stages SINGLE in the same cycle for 2 cycles (pcs A0,B0 then A1,B1), p=0 -> output order A0,B0,A1,B1, one record per cycle.
- Overflow: DEPTH=4, out_ready=0, stage0 SINGLE on 6 consecutive cycles -> 4 buffered, drop_count=2. Release out_ready and inject 1 more event -> first 4 records have lost=0, the 5th has lost=1.
- Backpressure: out_valid=1 with out_ready=0 for 3 cycles while the other stage pushes -> out_* unchanged all 3 cycles; the accepted record is the original one.
- Reset: assert rst_n=0 mid-multicycle with 3 records buffered -> out_valid=0 and drop_count=0 immediately. After release with busy still high, a START is emitted at ts=0 on the first traced cycle.
